// File: rtl/brg_cgra_xcel_link_dist_if.sv
// Handshake bundle between the CGRA pod, the link distributor and the IO router links.
// Signal suffixes are relative to the distributor, which uses the slave modport.
interface brg_cgra_xcel_link_dist_if #(
  parameter int num_cgra_p = 2,
  parameter int num_row_p  = 8,
  parameter int width_p    = 64
);
  logic [num_cgra_p-1:0]              cgra_req_v_i;
  logic [num_cgra_p-1:0][width_p-1:0] cgra_req_data_i;
  logic [num_cgra_p-1:0]              cgra_req_ready_o;
  logic [num_row_p-1:0]               link_req_v_o;
  logic [num_row_p-1:0][width_p-1:0]  link_req_data_o;
  logic [num_row_p-1:0]               link_req_ready_i;
  logic [num_row_p-1:0]               link_credit_i;
  logic [num_row_p-1:0]               link_resp_v_i;
  logic [num_row_p-1:0][width_p-1:0]  link_resp_data_i;
  logic [num_row_p-1:0]               link_resp_ready_o;
  logic [num_cgra_p-1:0]              cgra_resp_v_o;
  logic [num_cgra_p-1:0][width_p-1:0] cgra_resp_data_o;
  logic [num_cgra_p-1:0]              cgra_resp_ready_i;

  modport slave (
    input  cgra_req_v_i, cgra_req_data_i, link_req_ready_i, link_credit_i,
    input  link_resp_v_i, link_resp_data_i, cgra_resp_ready_i,
    output cgra_req_ready_o, link_req_v_o, link_req_data_o, link_resp_ready_o,
    output cgra_resp_v_o, cgra_resp_data_o
  );

  modport master (
    output cgra_req_v_i, cgra_req_data_i, link_req_ready_i, link_credit_i,
    output link_resp_v_i, link_resp_data_i, cgra_resp_ready_i,
    input  cgra_req_ready_o, link_req_v_o, link_req_data_o, link_resp_ready_o,
    input  cgra_resp_v_o, cgra_resp_data_o
  );
endinterface

// File: rtl/brg_cgra_xcel_link_dist.sv
// Steers CGRA requests onto credit-limited links of each CGRA's row group and
// round-robin merges the group's responses into one registered port per CGRA.
module brg_cgra_xcel_link_dist #(
  parameter int num_cgra_p        = 2,
  parameter int links_per_cgra_p  = 4,
  parameter int num_row_p         = num_cgra_p * links_per_cgra_p,
  parameter int width_p           = 64,
  parameter int max_out_credits_p = 16,
  localparam int cw_lp            = $clog2(max_out_credits_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            mode_i,
  brg_cgra_xcel_link_dist_if.slave        bus_if,
  output logic [num_row_p-1:0][cw_lp-1:0] out_credits_o,
  output logic [num_row_p-1:0]            credit_err_o,
  output logic                            idle_o
);
  localparam int lpc_lp = links_per_cgra_p;
  localparam int kw_lp  = (lpc_lp > 1) ? $clog2(lpc_lp) : 1;

  if (num_row_p != num_cgra_p * links_per_cgra_p) begin : g_bad_rows
    $error("num_row_p must equal num_cgra_p*links_per_cgra_p");
  end

  function automatic int wrap_k(input int base, input int ofs);
    return (base + ofs) % lpc_lp;
  endfunction

  logic [num_row_p-1:0][cw_lp-1:0]    cred_q, cred_d;
  logic [num_row_p-1:0]               err_q, err_d, elig, send;
  logic [num_cgra_p-1:0][kw_lp-1:0]   rr_ptr_q, lock_k_q, resp_ptr_q, sel_k, gnt_k;
  logic [num_cgra_p-1:0]              lock_q, sel_v, req_rdy, gnt_v, load_en, resp_v_q;
  logic [num_cgra_p-1:0][width_p-1:0] resp_data_q;

  // A locked selection wins over a fresh search so the link cannot move under a stalled request.
  always_comb begin
    for (int g = 0; g < num_row_p; g++) elig[g] = (cred_q[g] < cw_lp'(max_out_credits_p));
    for (int c = 0; c < num_cgra_p; c++) begin
      sel_v[c] = 1'b0;
      sel_k[c] = '0;
      if (lock_q[c]) begin
        sel_v[c] = 1'b1;
        sel_k[c] = lock_k_q[c];
      end else if (!mode_i) begin
        sel_v[c] = elig[c*lpc_lp];
      end else begin
        for (int i = lpc_lp - 1; i >= 0; i--) begin
          if (elig[c*lpc_lp + wrap_k(int'(rr_ptr_q[c]), i)]) begin
            sel_v[c] = 1'b1;
            sel_k[c] = kw_lp'(wrap_k(int'(rr_ptr_q[c]), i));
          end
        end
      end
      req_rdy[c] = sel_v[c] & bus_if.link_req_ready_i[c*lpc_lp + int'(sel_k[c])];
    end
    for (int g = 0; g < num_row_p; g++) begin
      bus_if.link_req_v_o[g]    = bus_if.cgra_req_v_i[g/lpc_lp] & sel_v[g/lpc_lp]
                                  & (sel_k[g/lpc_lp] == kw_lp'(g % lpc_lp));
      bus_if.link_req_data_o[g] = bus_if.cgra_req_data_i[g/lpc_lp];
      send[g]                   = bus_if.link_req_v_o[g] & bus_if.link_req_ready_i[g];
    end
    bus_if.cgra_req_ready_o = req_rdy;
  end

  always_comb begin
    for (int g = 0; g < num_row_p; g++) begin
      cred_d[g] = cred_q[g];
      err_d[g]  = err_q[g];
      if (send[g] && !bus_if.link_credit_i[g]) begin
        cred_d[g] = cred_q[g] + cw_lp'(1);
      end else if (!send[g] && bus_if.link_credit_i[g]) begin
        if (cred_q[g] == '0) err_d[g] = 1'b1;
        else cred_d[g] = cred_q[g] - cw_lp'(1);
      end
    end
  end

  // The output register refills in the same cycle it drains, keeping one response per cycle.
  always_comb begin
    bus_if.link_resp_ready_o = '0;
    for (int c = 0; c < num_cgra_p; c++) begin
      load_en[c] = ~resp_v_q[c] | bus_if.cgra_resp_ready_i[c];
      gnt_v[c]   = 1'b0;
      gnt_k[c]   = '0;
      for (int i = lpc_lp - 1; i >= 0; i--) begin
        if (bus_if.link_resp_v_i[c*lpc_lp + wrap_k(int'(resp_ptr_q[c]), i)]) begin
          gnt_v[c] = 1'b1;
          gnt_k[c] = kw_lp'(wrap_k(int'(resp_ptr_q[c]), i));
        end
      end
      if (load_en[c] && gnt_v[c]) bus_if.link_resp_ready_o[c*lpc_lp + int'(gnt_k[c])] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cred_q      <= '0;
      err_q       <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= '0;
      lock_k_q    <= '0;
      resp_ptr_q  <= '0;
      resp_v_q    <= '0;
      resp_data_q <= '0;
    end else begin
      cred_q <= cred_d;
      err_q  <= err_d;
      for (int c = 0; c < num_cgra_p; c++) begin
        lock_q[c]   <= bus_if.cgra_req_v_i[c] & sel_v[c] & ~req_rdy[c];
        lock_k_q[c] <= sel_k[c];
        if (mode_i && bus_if.cgra_req_v_i[c] && req_rdy[c])
          rr_ptr_q[c] <= kw_lp'(wrap_k(int'(sel_k[c]), 1));
        if (load_en[c]) begin
          resp_v_q[c] <= gnt_v[c];
          if (gnt_v[c]) begin
            resp_data_q[c] <= bus_if.link_resp_data_i[c*lpc_lp + int'(gnt_k[c])];
            resp_ptr_q[c]  <= kw_lp'(wrap_k(int'(gnt_k[c]), 1));
          end
        end
      end
    end
  end

  assign bus_if.cgra_resp_v_o    = resp_v_q;
  assign bus_if.cgra_resp_data_o = resp_data_q;
  assign out_credits_o           = cred_q;
  assign credit_err_o            = err_q;
  assign idle_o                  = (cred_q == '0) && (resp_v_q == '0);
endmodule

// File: tb/tb_brg_cgra_xcel_link_dist.sv
// Directed bench for the CGRA link distributor: request/response scoreboards plus
// direct checks of credit counts, lock behaviour, underflow and response stalls.
module tb_brg_cgra_xcel_link_dist;
  localparam int NC = 2, LPC = 4, NR = 8, W = 64, MAXC = 16, CW = 5;

  typedef struct packed { logic [3:0] link; logic [W-1:0] data; } req_t;
  typedef struct packed { logic cgra; logic [W-1:0] data; } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic [NR-1:0][CW-1:0] out_credits;
  logic [NR-1:0] credit_err;
  logic idle;
  int n_asrt = 0;
  int n_fail = 0;
  req_t req_q[$];
  rsp_t rsp_q[$];

  brg_cgra_xcel_link_dist_if #(.num_cgra_p(NC), .num_row_p(NR), .width_p(W)) lk();

  brg_cgra_xcel_link_dist #(
    .num_cgra_p(NC), .links_per_cgra_p(LPC), .num_row_p(NR),
    .width_p(W), .max_out_credits_p(MAXC)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .mode_i(mode), .bus_if(lk),
    .out_credits_o(out_credits), .credit_err_o(credit_err), .idle_o(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input int link, input logic [W-1:0] data);
    req_t e;
    e.link = 4'(link);
    e.data = data;
    req_q.push_back(e);
  endtask

  task automatic push_rsp(input int cgra, input logic [W-1:0] data);
    rsp_t e;
    e.cgra = 1'(cgra);
    e.data = data;
    rsp_q.push_back(e);
  endtask

  // One clock: observe handshakes about to complete, then advance to posedge+1.
  task automatic step();
    logic [NR-1:0] rsp_hs;
    req_t er;
    rsp_t ep;
    #1;
    rsp_hs = lk.link_resp_v_i & lk.link_resp_ready_o;
    for (int g = 0; g < NR; g++) begin
      if (lk.link_req_v_o[g] && lk.link_req_ready_i[g]) begin
        n_asrt++;
        assert (req_q.size() > 0) else begin
          n_fail++;
          $error("FAIL req_unexpected: observed send on link %0d, expected none", g);
        end
        if (req_q.size() > 0) begin
          er = req_q.pop_front();
          chk("req_link", 64'(g), 64'(er.link));
          chk("req_data", lk.link_req_data_o[g], er.data);
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (lk.cgra_resp_v_o[c] && lk.cgra_resp_ready_i[c]) begin
        n_asrt++;
        assert (rsp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL rsp_unexpected: observed response on cgra %0d, expected none", c);
        end
        if (rsp_q.size() > 0) begin
          ep = rsp_q.pop_front();
          chk("rsp_cgra", 64'(c), 64'(ep.cgra));
          chk("rsp_data", lk.cgra_resp_data_o[c], ep.data);
        end
      end
    end
    @(posedge clk);
    #1;
    lk.link_resp_v_i = lk.link_resp_v_i & ~rsp_hs;
  endtask

  task automatic clear_inputs();
    lk.cgra_req_v_i      = '0;
    lk.cgra_req_data_i   = '0;
    lk.link_req_ready_i  = '0;
    lk.link_credit_i     = '0;
    lk.link_resp_v_i     = '0;
    lk.link_resp_data_i  = '0;
    lk.cgra_resp_ready_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    @(posedge clk);
    #1;
    do_reset();
    chk("reset_credits", out_credits, '0);
    chk("reset_resp_v", lk.cgra_resp_v_o, '0);
    chk("reset_err", credit_err, '0);
    chk("reset_idle", idle, 1'b1);

    // Round-robin on CGRA0 while CGRA1 loads a response it will never drain.
    mode = 1'b1;
    lk.link_req_ready_i = '1;
    lk.link_resp_v_i[4] = 1'b1;
    lk.link_resp_data_i[4] = 64'hBEEF;
    for (int i = 0; i < 8; i++) begin
      lk.cgra_req_v_i[0] = 1'b1;
      lk.cgra_req_data_i[0] = 64'h1000 + 64'(i);
      push_req(i % 4, 64'h1000 + 64'(i));
      #1;
      chk("rr_ready", lk.cgra_req_ready_o[0], 1'b1);
      step();
    end
    lk.cgra_req_v_i = '0;
    for (int g = 0; g < 4; g++) chk("rr_count", out_credits[g], 5'd2);
    chk("held_resp_v", lk.cgra_resp_v_o[1], 1'b1);
    chk("busy_idle", idle, 1'b0);

    do_reset();
    chk("midrst_credits", out_credits, '0);
    chk("midrst_resp_v", lk.cgra_resp_v_o, '0);
    chk("midrst_idle", idle, 1'b1);

    // Static mode and credit limit on CGRA1 / link 4.
    mode = 1'b0;
    lk.link_req_ready_i = '1;
    lk.cgra_req_v_i[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      lk.cgra_req_data_i[1] = 64'h2000 + 64'(i);
      push_req(4, 64'h2000 + 64'(i));
      step();
    end
    lk.cgra_req_data_i[1] = 64'h2010;
    #1;
    chk("lim_count", out_credits[4], 5'd16);
    chk("lim_ready", lk.cgra_req_ready_o[1], 1'b0);
    chk("lim_link_v", lk.link_req_v_o[4], 1'b0);
    lk.link_credit_i[4] = 1'b1;
    step();
    lk.link_credit_i[4] = 1'b0;
    #1;
    chk("lim_after_credit", out_credits[4], 5'd15);
    chk("lim_ready2", lk.cgra_req_ready_o[1], 1'b1);
    push_req(4, 64'h2010);
    step();
    lk.cgra_req_v_i = '0;
    chk("lim_final", out_credits[4], 5'd16);
    chk("lim_link5", out_credits[5], 5'd0);

    // Lock: links 1..3 full, link 0 stalled, rr pointer at 1.
    do_reset();
    mode = 1'b1;
    lk.link_req_ready_i = '1;
    for (int i = 0; i < 64; i++) begin
      lk.cgra_req_v_i[0] = 1'b1;
      lk.cgra_req_data_i[0] = 64'h3000 + 64'(i);
      push_req(i % 4, 64'h3000 + 64'(i));
      step();
    end
    lk.cgra_req_v_i = '0;
    lk.link_credit_i[0] = 1'b1;
    for (int i = 0; i < 16; i++) step();
    lk.link_credit_i[0] = 1'b0;
    lk.cgra_req_v_i[0] = 1'b1;
    lk.cgra_req_data_i[0] = 64'h3100;
    push_req(0, 64'h3100);
    step();
    lk.cgra_req_v_i = '0;
    lk.link_credit_i[0] = 1'b1;
    step();
    lk.link_credit_i[0] = 1'b0;
    chk("lock_pre_count0", out_credits[0], 5'd0);
    chk("lock_pre_count1", out_credits[1], 5'd16);
    lk.link_req_ready_i[0] = 1'b0;
    lk.cgra_req_v_i[0] = 1'b1;
    lk.cgra_req_data_i[0] = 64'hA5A5;
    #1;
    chk("lock_v0", lk.link_req_v_o[3:0], 4'b0001);
    chk("lock_rdy0", lk.cgra_req_ready_o[0], 1'b0);
    step();
    lk.link_credit_i[1] = 1'b1;
    #1;
    chk("lock_v1", lk.link_req_v_o[3:0], 4'b0001);
    step();
    lk.link_credit_i[1] = 1'b0;
    #1;
    chk("lock_v2", lk.link_req_v_o[3:0], 4'b0001);
    step();
    lk.link_req_ready_i[0] = 1'b1;
    push_req(0, 64'hA5A5);
    #1;
    chk("lock_rdy_release", lk.cgra_req_ready_o[0], 1'b1);
    step();
    lk.cgra_req_v_i = '0;
    chk("lock_count0", out_credits[0], 5'd1);
    chk("lock_count1", out_credits[1], 5'd15);

    // Same-cycle send and credit, then underflow.
    do_reset();
    mode = 1'b0;
    lk.link_req_ready_i = '1;
    lk.cgra_req_v_i[0] = 1'b1;
    lk.cgra_req_data_i[0] = 64'h4000;
    push_req(0, 64'h4000);
    step();
    lk.cgra_req_data_i[0] = 64'h4001;
    lk.link_credit_i[0] = 1'b1;
    push_req(0, 64'h4001);
    step();
    chk("sim_count", out_credits[0], 5'd1);
    lk.cgra_req_v_i = '0;
    step();
    chk("ret_count", out_credits[0], 5'd0);
    chk("ret_noerr", credit_err, 8'h00);
    step();
    lk.link_credit_i = '0;
    chk("uf_err", credit_err, 8'h01);
    chk("uf_count", out_credits[0], 5'd0);
    step();
    chk("uf_sticky", credit_err, 8'h01);

    // Response arbitration on CGRA0.
    do_reset();
    lk.cgra_resp_ready_i[0] = 1'b1;
    lk.link_resp_v_i[0] = 1'b1;
    lk.link_resp_data_i[0] = 64'hD000;
    lk.link_resp_v_i[2] = 1'b1;
    lk.link_resp_data_i[2] = 64'hD002;
    push_rsp(0, 64'hD000);
    push_rsp(0, 64'hD002);
    #1;
    chk("arb_rdy_t", lk.link_resp_ready_o[3:0], 4'b0001);
    step();
    chk("arb_v_t1", lk.cgra_resp_v_o[0], 1'b1);
    chk("arb_d_t1", lk.cgra_resp_data_o[0], 64'hD000);
    #1;
    chk("arb_rdy_t1", lk.link_resp_ready_o[3:0], 4'b0100);
    step();
    chk("arb_d_t2", lk.cgra_resp_data_o[0], 64'hD002);
    step();
    chk("arb_drained", lk.cgra_resp_v_o[0], 1'b0);

    // Stall: pointer now at 3, so link 3 wins over link 1.
    lk.cgra_resp_ready_i[0] = 1'b0;
    lk.link_resp_v_i[1] = 1'b1;
    lk.link_resp_data_i[1] = 64'hE001;
    lk.link_resp_v_i[3] = 1'b1;
    lk.link_resp_data_i[3] = 64'hE003;
    push_rsp(0, 64'hE003);
    push_rsp(0, 64'hE001);
    #1;
    chk("stall_rdy_load", lk.link_resp_ready_o[3:0], 4'b1000);
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_v", lk.cgra_resp_v_o[0], 1'b1);
      chk("stall_d", lk.cgra_resp_data_o[0], 64'hE003);
      chk("stall_rdy", lk.link_resp_ready_o[3:0], 4'b0000);
      step();
    end
    lk.cgra_resp_ready_i[0] = 1'b1;
    #1;
    chk("stall_refill", lk.link_resp_ready_o[3:0], 4'b0010);
    step();
    step();
    lk.link_resp_v_i = '0;
    chk("end_idle", idle, 1'b1);
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/brg_cgra_xcel_link_dist.md
Name: brg_cgra_xcel_link_dist

Overview:
- Parametrised link distributor between the proc-side links of a horizontal IO router column and a CGRA accelerator pod that holds num_cgra_p accelerators.
- Each accelerator owns a contiguous group of links_per_cgra_p rows.
- Outgoing requests are steered onto one link of the owner's group, under per-link credit limits, in static or round-robin mode.
- Returning responses from the group are arbitrated round-robin into one registered response port per accelerator.

Parameters:
- num_cgra_p, 2: number of CGRA accelerators.
- links_per_cgra_p, 4: links per CGRA. num_row_p = num_cgra_p*links_per_cgra_p; any other value is an elaboration error.
- width_p, 64: packet width for both request and response.
- max_out_credits_p, 16: outstanding requests allowed per link. Credit counter width is cw = clog2(max_out_credits_p+1).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; synchronous, active-low.
- mode_i  in  1  0 = static (first link of group only), 1 = round-robin across group. Changes only while idle_o=1.
- cgra_req_v_i  in  [num_cgra_p]  request valid.
- cgra_req_data_i  in  [num_cgra_p][width_p]  request packet.
- cgra_req_ready_o  out  [num_cgra_p]  request accepted.
- link_req_v_o  out  [num_row_p]  link request valid.
- link_req_data_o  out  [num_row_p][width_p]  link request packet.
- link_req_ready_i  in  [num_row_p]  link ready.
- link_credit_i  in  [num_row_p]  one-cycle credit return pulse.
- link_resp_v_i  in  [num_row_p]  response valid.
- link_resp_data_i  in  [num_row_p][width_p]  response packet.
- link_resp_ready_o  out  [num_row_p]  response consumed.
- cgra_resp_v_o  out  [num_cgra_p]  registered response valid.
- cgra_resp_data_o  out  [num_cgra_p][width_p]  registered response packet.
- cgra_resp_ready_i  in  [num_cgra_p]  CGRA ready.
- out_credits_o  out  [num_row_p][cw]  outstanding count per link.
- credit_err_o  out  [num_row_p]  sticky credit underflow flag.
- idle_o  out  1  all counters 0 and no response held.

Behaviour:
- Reset (reset_n_i=0 at a posedge) values: counters 0, rr pointers 0, lock flags 0, cgra_resp_v_o 0, credit_err_o 0, idle_o 1.
- Reset mid-operation discards held responses and outstanding counts with no drain.
- Link group: CGRA c owns links g = c*links_per_cgra_p + k, for k = 0..links_per_cgra_p-1.
- Eligibility: link g is eligible iff out_credits[g] < max_out_credits_p. Link ready does not enter eligibility, so valid never depends on ready.
- Selection, mode 0: the selected link is k=0 whenever it is eligible; otherwise there is no selection.
- Selection, mode 1: the selected link is the first eligible k searching from rr_ptr[c] upward with wrap.
- Request path (combinational pass-through, zero latency):
  - link_req_v_o[g] = cgra_req_v_i[c] AND g selected.
  - link_req_data_o[g] = cgra_req_data_i[c].
  - cgra_req_ready_o[c] = link_req_ready_i[selected], or 0 if there is no selection.
- Selection lock:
  - When v is high and ready is low, the current selection is registered and held until the handshake, even if credit returns make an earlier link eligible.
  - Valid is held by the CGRA per the valid/ready rule.
  - The lock clears on handshake.
- Pointer update: on a handshake in mode 1, rr_ptr[c] <= (k_sel+1) mod links_per_cgra_p. In mode 0 the pointer is unchanged.
- Credit counter, per link per cycle:
  - send only: +1.
  - link_credit_i only: -1.
  - both: unchanged.
  - link_credit_i while count==0 with no send: count stays 0 and credit_err_o[g] is set; it clears only on reset.
  - A send at count==max_out_credits_p cannot occur, because the link is ineligible.
- Response path, one output register per CGRA:
  - The register loads when it is empty, or when cgra_resp_v_o & cgra_resp_ready_i in the same cycle, so full throughput is kept.
  - Grant goes to the first valid link in the group, searching from resp_ptr[c] with wrap.
  - link_resp_ready_o is high only for the granted link, in the load cycle.
  - After a grant, resp_ptr[c] <= granted k + 1 mod links_per_cgra_p.
  - Latency: link handshake at cycle t gives cgra_resp_v_o high from t+1.
  - The register holds its data stable while not ready.
- idle_o is combinational from the counters and response valids.

Test Plan:
- Reset: drive traffic, then reset_n_i=0 for 1 cycle → all out_credits_o=0, cgra_resp_v_o=0, idle_o=1, credit_err_o=0 at the next cycle.
- Round-robin: mode 1, CGRA0 sends 8 back-to-back requests with all links ready and no credit return → links 0,1,2,3,0,1,2,3 are used and each out_credits_o=2.
- Static plus credit limit: mode 0, max_out_credits_p=16, CGRA1 sends 17 requests with no credits → link 4 count is 16 and cgra_req_ready_o[1]=0 on the 17th. A credit pulse on link 4 → the 17th is accepted the next cycle and the count stays 16.
- Lock: mode 1, links 1–3 full, link 0 not ready, request pending; a credit pulse on link 1 → link_req_v_o stays on link 0 until ready. Then the count pattern is 1 (link0), 15 (link1).
- Simultaneous events and underflow: send and credit on the same link in the same cycle → count unchanged. Credit with count 0 → credit_err_o=1 and the count stays 0.
- Response arbitration: links 0 and 2 valid together with cgra_resp_ready_i=1 → link 0 data appears at t+1 and link 2 at t+2. With ready held low for 3 cycles, the data stays stable and both link_resp_ready_o stay low.
